// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the acquisition sequencer: state codes, default widths
// and the firmware auto-trigger mode code.
package capture_ctrl_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  // Trigger-block mode code used by firmware to force an unconditional trigger.
  localparam logic [7:0] MODE_AUTO_TRIG = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // States in which the trigger block is released from reset and may fire.
  function automatic logic trig_armed(input state_t s);
    return (s == ST_WAIT) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Control/status bundle between the capture sequencer (master) and the MCU,
// trigger block and sample buffer (slave).
interface capture_ctrl_if
  import capture_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          Arm;
  logic          Stop;
  logic [DW-1:0] Smpl_Div;
  logic [AW-1:0] Pre_Depth;
  logic [AW-1:0] Buf_Depth;
  logic          Start;
  logic          Trig_Rst;
  logic          Sampled;
  logic          Wr_En;
  logic [AW-1:0] Wr_Addr;
  logic [AW-1:0] Trig_Addr;
  logic          Busy;
  logic          Done;
  logic [2:0]    State;

  modport master (
    input  Arm, Stop, Smpl_Div, Pre_Depth, Buf_Depth, Start,
    output Trig_Rst, Sampled, Wr_En, Wr_Addr, Trig_Addr, Busy, Done, State
  );

  modport slave (
    output Arm, Stop, Smpl_Div, Pre_Depth, Buf_Depth, Start,
    input  Trig_Rst, Sampled, Wr_En, Wr_Addr, Trig_Addr, Busy, Done, State
  );

endinterface

// File: rtl/capture_ctrl_smpl_div.sv
// Sample-rate divider: pulses Smp once every Div+1 enabled Mclk cycles,
// restarting its phase whenever Clr is asserted.
module smpl_div
  import capture_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          Reset,
  input  logic          Mclk,
  input  logic          En,
  input  logic          Clr,
  input  logic [DW-1:0] Div,
  output logic          Smp
);

  logic [DW-1:0] cnt;

  // A restart never produces a strobe on the same cycle it realigns the phase.
  assign Smp = En && !Clr && (cnt == Div);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Mclk or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (Clr) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= (cnt == Div) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: paces circular-buffer writes, fills the pre-trigger
// window, waits for Start, counts post-trigger samples and reports Done.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic            Reset,
  input logic            Mclk,
  capture_ctrl_if.master bus
);

  state_t        state, state_nx;
  logic          smp, busy, post_last;
  logic          trig_rst, sampled, wr_en, done;
  logic [AW-1:0] wr_addr, trig_addr, pre_cnt;
  logic [AW-1:0] bd_m1, pd_eff;
  logic [AW:0]   bd_eff, post_eff, post_cnt;

  // Buf_Depth=0 means a full buffer; its minus-one then wraps to all ones.
  always_comb begin
    bd_eff   = (bus.Buf_Depth == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, bus.Buf_Depth};
    bd_m1    = bus.Buf_Depth - 1'b1;
    pd_eff   = (bus.Pre_Depth > bd_m1) ? bd_m1 : bus.Pre_Depth;
    post_eff = bd_eff - {1'b0, pd_eff};
  end

  assign busy      = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign post_last = (state == ST_POST) && (post_cnt == '0);

  smpl_div #(.DW(DW)) u_smpl_div (
    .Reset (Reset),
    .Mclk  (Mclk),
    .En    (busy),
    .Clr   (bus.Arm),
    .Div   (bus.Smpl_Div),
    .Smp   (smp)
  );

  always_comb begin
    // NOTE: state_nx gets a default first so no path through this block infers a latch.
    state_nx = state;
    if (bus.Stop) begin
      state_nx = ST_IDLE;
    end else if (bus.Arm) begin
      state_nx = ST_PRE;
    end else begin
      case (state)
        ST_PRE:  if (pre_cnt == '0 || (smp && pre_cnt == AW'(1))) state_nx = ST_WAIT;
        ST_WAIT: if (bus.Start) state_nx = ST_POST;
        ST_POST: if (post_last) state_nx = ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Mclk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      trig_rst  <= 1'b1;
      sampled   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      trig_addr <= '0;
      done      <= 1'b0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
    end else begin
      state    <= state_nx;
      trig_rst <= !trig_armed(state_nx);
      sampled  <= trig_armed(state_nx);
      // The strobe that lands while the last post sample is being written is not a sample.
      wr_en    <= smp && !bus.Stop && !post_last;
      if (wr_en) wr_addr <= wr_addr + 1'b1;

      if (!bus.Stop) begin
        if (bus.Arm) begin
          pre_cnt  <= pd_eff;
          post_cnt <= post_eff;
          done     <= 1'b0;
        end else begin
          if (state == ST_PRE && smp && pre_cnt != '0) pre_cnt <= pre_cnt - 1'b1;
          if (state == ST_POST && smp && post_cnt != '0) post_cnt <= post_cnt - 1'b1;
          if (state == ST_WAIT && bus.Start) trig_addr <= wr_addr;
          if (post_last) done <= 1'b1;
        end
      end
    end
  end

  assign bus.Trig_Rst  = trig_rst;
  assign bus.Sampled   = sampled;
  assign bus.Wr_En     = wr_en;
  assign bus.Wr_Addr   = wr_addr;
  assign bus.Trig_Addr = trig_addr;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.State     = state;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: randomized captures compared each cycle
// against a timeline model computed arithmetically from the capture parameters.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int NA = 1 << AW;

  logic Reset;
  logic Mclk;

  capture_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  capture_ctrl #(.AW(AW), .DW(DW)) dut (
    .Reset (Reset),
    .Mclk  (Mclk),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          we;
    logic          busy;
    logic          samp;
    logic          trst;
    logic          done;
    logic [AW-1:0] addr;
    logic [AW-1:0] trig;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_addr = 0;   // model: next buffer address to be written
  int m_trig = 0;   // model: latched trigger address
  bit m_done = 1'b0;

  initial Mclk = 1'b0;
  always #5 Mclk = ~Mclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t observe();
    obs_t o;
    o.st   = bus.State;
    o.we   = bus.Wr_En;
    o.busy = bus.Busy;
    o.samp = bus.Sampled;
    o.trst = bus.Trig_Rst;
    o.done = bus.Done;
    o.addr = bus.Wr_Addr;
    o.trig = bus.Trig_Addr;
    return o;
  endfunction

  function automatic obs_t idle_obs(input int addr, input int trig, input bit dn);
    obs_t o;
    o.st   = 3'd0;
    o.we   = 1'b0;
    o.busy = 1'b0;
    o.samp = 1'b0;
    o.trst = 1'b1;
    o.done = dn;
    o.addr = AW'(addr);
    o.trig = AW'(trig);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d we=%b busy=%b samp=%b trst=%b done=%b addr=%0d trig=%0d",
                     o.st, o.we, o.busy, o.samp, o.trst, o.done, o.addr, o.trig);
  endfunction

  // kind: 0 complete capture, 1 Arm+Start together at the Start cycle,
  //       2 Stop at POST cycle offset ab_off, 3 async Reset at POST offset ab_off.
  task automatic run_capture(input string name, input int div, input int bd_raw,
                             input int pd_raw, input int wait_cyc, input int kind,
                             input int ab_off, input bit pre_armed);
    int   bd, pd, post, w, s, f, l, x, last_t, snap;
    obs_t e, g;
    bd   = (bd_raw == 0) ? NA : bd_raw;
    pd   = (pd_raw > bd - 1) ? bd - 1 : pd_raw;
    post = bd - pd;
    // Samples fall on cycles k*(div+1), k>=1, counted from the first cycle after Arm.
    w    = (pd > 0) ? pd * (div + 1) + 1 : 2;
    s    = w + wait_cyc;
    f    = ((s + 1 + div) / (div + 1)) * (div + 1);
    l    = f + (post - 1) * (div + 1);
    x    = s + 1 + ab_off;
    last_t = (kind == 1) ? s : (kind >= 2) ? x : l + 2;
    snap = m_trig;
    if (!pre_armed) begin
      bus.Smpl_Div  = DW'(div);
      bus.Buf_Depth = AW'(bd_raw);
      bus.Pre_Depth = AW'(pd_raw);
      bus.Arm       = 1'b1;
    end
    m_done = 1'b0;
    for (int t = 1; t <= last_t; t++) begin
      @(negedge Mclk);
      bus.Arm = 1'b0;
      if (t == s + 1) m_trig = snap;
      e.st   = (t < w) ? 3'd1 : (t <= s) ? 3'd2 : (t <= l + 1) ? 3'd3 : 3'd4;
      e.we   = (t - 1 >= div + 1) && ((t - 1) % (div + 1) == 0) && (t - 1 <= l);
      e.busy = (e.st >= 3'd1) && (e.st <= 3'd3);
      e.samp = (e.st == 3'd2) || (e.st == 3'd3);
      e.trst = !e.samp;
      e.done = (e.st == 3'd4);
      e.addr = AW'(m_addr);
      e.trig = AW'(m_trig);
      if (e.done) m_done = 1'b1;
      if (t == s) snap = m_addr;
      g = observe();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got {%s} want {%s}", name, t, fmt(g), fmt(e));
      end
      if (e.we) m_addr = (m_addr + 1) % NA;
      bus.Start = (t == s) ? 1'b1 : (t < w || t > s) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (kind == 1 && t == s) bus.Arm = 1'b1;
      if (kind == 2 && t == x) bus.Stop = 1'b1;
    end

    if (kind == 0) bus.Start = 1'b0;
    if (kind == 2) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge Mclk);
        g = observe();
        n_cmp++;
        if (g !== idle_obs(m_addr, m_trig, m_done)) begin
          n_bad++;
          $display("FAIL %s after stop %0d: got {%s} want {%s}", name, k, fmt(g),
                   fmt(idle_obs(m_addr, m_trig, m_done)));
        end
        bus.Start = 1'b0;
        if (k == 2) bus.Stop = 1'b0;
      end
    end
    if (kind == 3) begin
      bus.Start = 1'b0;
      #2 Reset = 1'b1;
      #1;
      g = observe();
      n_cmp++;
      if (g !== idle_obs(0, 0, 1'b0)) begin
        n_bad++;
        $display("FAIL %s immediate reset: got {%s} want {%s}", name, fmt(g),
                 fmt(idle_obs(0, 0, 1'b0)));
      end
      @(negedge Mclk);
      Reset  = 1'b0;
      m_addr = 0;
      m_trig = 0;
      m_done = 1'b0;
      g = observe();
      n_cmp++;
      if (g !== idle_obs(0, 0, 1'b0)) begin
        n_bad++;
        $display("FAIL %s held reset: got {%s} want {%s}", name, fmt(g), fmt(idle_obs(0, 0, 1'b0)));
      end
    end
  endtask

  task automatic test_reset();
    obs_t g;
    Reset = 1'b1;
    bus.Arm = 1'b0; bus.Stop = 1'b0; bus.Start = 1'b0;
    bus.Smpl_Div = '0; bus.Pre_Depth = '0; bus.Buf_Depth = '0;
    repeat (2) @(negedge Mclk);
    g = observe();
    n_cmp++;
    if (g !== idle_obs(0, 0, 1'b0)) begin
      n_bad++;
      $display("FAIL reset_held: got {%s} want {%s}", fmt(g), fmt(idle_obs(0, 0, 1'b0)));
    end
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Mclk);
      bus.Start = 1'($urandom_range(0, 1));
      g = observe();
      n_cmp++;
      if (g !== idle_obs(0, 0, 1'b0)) begin
        n_bad++;
        $display("FAIL reset_idle %0d: got {%s} want {%s}", k, fmt(g), fmt(idle_obs(0, 0, 1'b0)));
      end
    end
    bus.Start = 1'b0;
  endtask

  task automatic test_basic();
    run_capture("basic", 0, 16, 4, 10, 0, 0, 1'b0);
    n_cmp++;
    if (bus.Trig_Addr !== AW'(13) || bus.Wr_Addr !== AW'(27) || bus.Done !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_totals: got trig=%0d addr=%0d done=%b want trig=13 addr=27 done=1",
               bus.Trig_Addr, bus.Wr_Addr, bus.Done);
    end
  endtask

  task automatic test_divider();
    run_capture("divider", 3, 8, 0, 5, 0, 0, 1'b0);
    run_capture("divider_pre", 2, 10, 3, 1, 0, 0, 1'b0);
  endtask

  task automatic test_clamp_zero();
    run_capture("clamp", 1, 16, 20, 3, 0, 0, 1'b0);
    run_capture("zero_depth", 0, 0, 7, 2, 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    int rem;
    rem = (4090 - m_addr + NA) % NA;
    if (rem >= 4) run_capture("wrap_pad", 0, rem - 2, 1, 1, 0, 0, 1'b0);
    else          run_capture("wrap_pad", 0, 4095, 1, rem, 0, 0, 1'b0);
    run_capture("wrap", 0, 16, 8, 3, 0, 0, 1'b0);
    n_cmp++;
    if (bus.Trig_Addr !== AW'(4) || bus.Wr_Addr !== AW'(14)) begin
      n_bad++;
      $display("FAIL wrap_totals: got trig=%0d addr=%0d want trig=4 addr=14",
               bus.Trig_Addr, bus.Wr_Addr);
    end
  endtask

  task automatic test_priority();
    run_capture("prio_arm_start", 1, 12, 3, 4, 1, 0, 1'b0);
    run_capture("prio_restart", 1, 12, 3, 2, 0, 0, 1'b1);
    run_capture("stop_post", 2, 20, 5, 3, 2, 4, 1'b0);
  endtask

  task automatic test_async_reset();
    run_capture("async_rst", 0, 20, 5, 2, 3, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_capture($sformatf("random%0d", i), int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 40)), int'($urandom_range(0, 45)),
                  int'($urandom_range(0, 10)), 0, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_clamp_zero();
    test_wrap();
    test_priority();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
